// File: rtl/svm_pkg.sv
// Shared types and helpers for the squared-distance engine: accumulator sizing,
// FSM state encoding and unsigned saturation.
package svm_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_e;

  // Beats between final-beat accept and the accumulator holding the full sum.
  localparam int DRAIN_CYC = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Enough headroom for MAX_DIM full-scale squares without wrap.
  function automatic int acc_w(input int feat_w, input int max_dim);
    return 2 * feat_w + clog2(max_dim);
  endfunction

  function automatic logic [63:0] sat_u(input logic [63:0] v, input int unsigned w);
    logic [63:0] lim;
    lim = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/svm_sqdist_engine_if.sv
// Feature-pair input stream and distance output stream of the engine.
interface svm_sqdist_engine_if #(
  parameter int LANES  = 4,
  parameter int FEAT_W = 16,
  parameter int DIST_W = 32
);
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*FEAT_W-1:0]   in_x;
  logic [LANES*FEAT_W-1:0]   in_z;
  logic                      out_valid;
  logic                      out_ready;
  logic [DIST_W-1:0]         out_dist;
  logic [15:0]               out_idx;

  modport master (
    output in_valid, in_x, in_z, out_ready,
    input  in_ready, out_valid, out_dist, out_idx
  );

  modport slave (
    input  in_valid, in_x, in_z, out_ready,
    output in_ready, out_valid, out_dist, out_idx
  );
endinterface

// File: rtl/svm_sqdiff_lane.sv
// One feature lane: registered |x-z| then registered square. Invalid or masked
// beats produce zero so the adder tree needs no per-lane gating.
module svm_sqdiff_lane #(
  parameter int FEAT_W = 16
) (
  input  logic                  clk_svm,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic                  mask_i,
  input  logic [FEAT_W-1:0]     x_i,
  input  logic [FEAT_W-1:0]     z_i,
  output logic [2*FEAT_W-1:0]   sq_o
);
  localparam int SQ_W = 2 * FEAT_W;

  logic [FEAT_W-1:0] d_q, d_d;
  logic [SQ_W-1:0]   sq_q;

  always_comb begin
    d_d = '0;
    if (valid_i && !mask_i)
      d_d = (x_i >= z_i) ? (x_i - z_i) : (z_i - x_i);
  end

  always_ff @(posedge clk_svm) begin
    if (rst) begin
      d_q  <= '0;
      sq_q <= '0;
    end else begin
      d_q  <= d_d;
      sq_q <= SQ_W'(d_q) * SQ_W'(d_q);
    end
  end

  assign sq_o = sq_q;
endmodule

// File: rtl/svm_sqdist_engine.sv
// Streaming squared-Euclidean-distance engine: LANES feature pairs per beat, one
// saturated distance per vector. Optional SVM_GAMMA_SHIFT_EN applies acc >> cfg_shift.
module svm_sqdist_engine
  import svm_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int FEAT_W  = 16,
  parameter int MAX_DIM = 1024,
  parameter int DIST_W  = 32
) (
  input  logic                 clk_svm,
  input  logic                 rst,
  input  logic                 start,
  input  logic [15:0]          cfg_num_dim,
  input  logic [15:0]          cfg_num_samples,
  input  logic [4:0]           cfg_shift,
  svm_sqdist_engine_if.slave   io,
  output logic                 busy,
  output logic                 done
);
  localparam int ACC_W  = acc_w(FEAT_W, MAX_DIM);
  localparam int STAGES = 2;

  state_e                          state_q;
  logic [15:0]                     nbeats_q, rem_q, beat_cnt_q, idx_q, nsamp_q;
  logic [15:0]                     nbeats_d, rem_d;
  logic [1:0]                      drain_cnt_q;
  logic                            in_ready_q, out_valid_q, busy_q, done_q;
  logic [DIST_W-1:0]               out_dist_q;
  logic [STAGES:0]                 vld_pipe;
  logic [ACC_W-1:0]                acc_q, tree_q, tree_d, acc_sh;

  logic [LANES-1:0][FEAT_W-1:0]    x_arr, z_arr;
  logic [LANES-1:0][2*FEAT_W-1:0]  sq;
  logic [LANES-1:0]                lane_mask;
  logic                            fire, last_beat, cfg_ok, out_hs;

  assign x_arr     = io.in_x;
  assign z_arr     = io.in_z;
  assign fire      = io.in_valid && in_ready_q;
  assign last_beat = (beat_cnt_q == nbeats_q - 16'd1);
  assign out_hs    = (state_q == OUT) && io.out_ready;
  assign cfg_ok    = (cfg_num_dim != '0) && (cfg_num_samples != '0) &&
                     (cfg_num_dim <= 16'(MAX_DIM));
  assign nbeats_d  = 16'((17'(cfg_num_dim) + 17'(LANES - 1)) / 17'(LANES));
  assign rem_d     = 16'(cfg_num_dim % 16'(LANES));

  // Lanes beyond the vector length on the final beat carry don't-care data.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_mask[l] = last_beat && (rem_q != '0) && (16'(l) >= rem_q);

    svm_sqdiff_lane #(.FEAT_W(FEAT_W)) u_lane (
      .clk_svm (clk_svm),
      .rst     (rst),
      .valid_i (fire),
      .mask_i  (lane_mask[l]),
      .x_i     (x_arr[l]),
      .z_i     (z_arr[l]),
      .sq_o    (sq[l])
    );
  end

  always_comb begin
    tree_d = '0;
    for (int l = 0; l < LANES; l++)
      tree_d = tree_d + ACC_W'(sq[l]);
  end

`ifdef SVM_GAMMA_SHIFT_EN
  logic [4:0] shift_q;
  always_ff @(posedge clk_svm) begin
    if (rst)
      shift_q <= '0;
    else if (state_q == IDLE && start && cfg_ok)
      shift_q <= cfg_shift;
  end
  assign acc_sh = acc_q >> shift_q;
`else
  logic cfg_shift_unused;
  assign cfg_shift_unused = ^cfg_shift;
  assign acc_sh = acc_q;
`endif

  // Datapath: vld_pipe tracks a beat through diff, square and tree stages.
  always_ff @(posedge clk_svm) begin
    if (rst) begin
      vld_pipe <= '0;
      tree_q   <= '0;
      acc_q    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], fire};
      tree_q   <= tree_d;
      if (out_hs)
        acc_q <= '0;
      else if (vld_pipe[STAGES])
        acc_q <= acc_q + tree_q;
    end
  end

  always_ff @(posedge clk_svm) begin
    if (rst) begin
      state_q     <= IDLE;
      nbeats_q    <= '0;
      rem_q       <= '0;
      beat_cnt_q  <= '0;
      idx_q       <= '0;
      nsamp_q     <= '0;
      drain_cnt_q <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_dist_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && cfg_ok) begin
            nbeats_q   <= nbeats_d;
            rem_q      <= rem_d;
            nsamp_q    <= cfg_num_samples;
            beat_cnt_q <= '0;
            idx_q      <= '0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
            state_q    <= ACCUM;
          end
        end
        ACCUM: begin
          if (fire) begin
            if (last_beat) begin
              beat_cnt_q  <= '0;
              drain_cnt_q <= '0;
              in_ready_q  <= 1'b0;
              state_q     <= DRAIN;
            end else begin
              beat_cnt_q <= beat_cnt_q + 16'd1;
            end
          end
        end
        DRAIN: begin
          drain_cnt_q <= drain_cnt_q + 2'd1;
          if (drain_cnt_q == 2'(DRAIN_CYC - 1)) begin
            out_dist_q  <= DIST_W'(sat_u(64'(acc_sh), DIST_W));
            out_valid_q <= 1'b1;
            state_q     <= OUT;
          end
        end
        OUT: begin
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            if (idx_q == nsamp_q - 16'd1) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              idx_q      <= idx_q + 16'd1;
              in_ready_q <= 1'b1;
              state_q    <= ACCUM;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out_dist  = out_dist_q;
  assign io.out_idx   = idx_q;
  assign busy         = busy_q;
  assign done         = done_q;
endmodule

// File: tb/tb_svm_sqdist_engine.sv
// Directed bench: a 32-bit and a 16-bit-output engine driven in lockstep.
module tb_svm_sqdist_engine;
`ifdef SVM_GAMMA_SHIFT_EN
  localparam bit SH_EN = 1'b1;
`else
  localparam bit SH_EN = 1'b0;
`endif

  logic        clk_svm = 1'b0;
  logic        rst, start, in_valid, out_ready;
  logic [15:0] cfg_num_dim, cfg_num_samples;
  logic [4:0]  cfg_shift;
  logic [63:0] in_x, in_z;
  logic        busy_m, done_m, busy_s, done_s;
  int          n_chk = 0, n_fail = 0, done_cnt = 0;

  always #5 clk_svm = ~clk_svm;

  svm_sqdist_engine_if #(.LANES(4), .FEAT_W(16), .DIST_W(32)) m_if ();
  svm_sqdist_engine_if #(.LANES(4), .FEAT_W(16), .DIST_W(16)) s_if ();

  assign m_if.in_valid  = in_valid;
  assign m_if.in_x      = in_x;
  assign m_if.in_z      = in_z;
  assign m_if.out_ready = out_ready;
  assign s_if.in_valid  = in_valid;
  assign s_if.in_x      = in_x;
  assign s_if.in_z      = in_z;
  assign s_if.out_ready = out_ready;

  svm_sqdist_engine #(.LANES(4), .FEAT_W(16), .MAX_DIM(1024), .DIST_W(32)) u_dut (
    .clk_svm(clk_svm), .rst(rst), .start(start), .cfg_num_dim(cfg_num_dim),
    .cfg_num_samples(cfg_num_samples), .cfg_shift(cfg_shift), .io(m_if),
    .busy(busy_m), .done(done_m));

  svm_sqdist_engine #(.LANES(4), .FEAT_W(16), .MAX_DIM(1024), .DIST_W(16)) u_sat (
    .clk_svm(clk_svm), .rst(rst), .start(start), .cfg_num_dim(cfg_num_dim),
    .cfg_num_samples(cfg_num_samples), .cfg_shift(cfg_shift), .io(s_if),
    .busy(busy_s), .done(done_s));

  always @(negedge clk_svm) if (done_m) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] expd(input logic [63:0] acc, input int w, input int sh);
    logic [63:0] v, lim;
    v   = SH_EN ? (acc >> sh) : acc;
    lim = (64'd1 << w) - 64'd1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic do_start(input logic [15:0] dim, input logic [15:0] ns, input logic [4:0] sh);
    @(negedge clk_svm);
    cfg_num_dim = dim; cfg_num_samples = ns; cfg_shift = sh; start = 1'b1;
    @(negedge clk_svm);
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] x, input logic [63:0] z);
    int t;
    @(negedge clk_svm);
    in_valid = 1'b1; in_x = x; in_z = z;
    t = 0;
    while (!m_if.in_ready && t < 50) begin @(negedge clk_svm); t++; end
    chk("in_ready", 64'(m_if.in_ready), 64'd1);
    @(posedge clk_svm); #1;
    in_valid = 1'b0; in_x = '1; in_z = '1;
  endtask

  task automatic get_result(input string tag, input logic [63:0] acc, input int sh,
                            input logic [15:0] idx, input bit last);
    int t;
    t = 0;
    while (!m_if.out_valid && t < 50) begin @(negedge clk_svm); t++; end
    chk({tag, "_valid"}, 64'(m_if.out_valid), 64'd1);
    chk({tag, "_dist32"}, 64'(m_if.out_dist), expd(acc, 32, sh));
    chk({tag, "_dist16"}, 64'(s_if.out_dist), expd(acc, 16, sh));
    chk({tag, "_idx"}, 64'(m_if.out_idx), 64'(idx));
    out_ready = 1'b1;
    @(posedge clk_svm); #1;
    out_ready = 1'b0;
    @(negedge clk_svm);
    chk({tag, "_vld_drop"}, 64'(m_if.out_valid), 64'd0);
    if (last) begin
      chk({tag, "_done"}, 64'(done_m), 64'd1);
      chk({tag, "_busy"}, 64'(busy_m), 64'd0);
      @(negedge clk_svm);
      chk({tag, "_done_pulse"}, 64'(done_m), 64'd0);
    end
  endtask

  localparam logic [63:0] X1 = {16'd40, 16'd30, 16'd20, 16'd10};
  localparam logic [63:0] Z1 = {16'd0,  16'd30, 16'd25, 16'd7};

  initial begin
    int dc;
    logic [31:0] held;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cfg_num_dim = '0; cfg_num_samples = '0; cfg_shift = '0; in_x = '0; in_z = '0;
    repeat (3) @(negedge clk_svm);
    chk("rst_busy", 64'(busy_m), 64'd0);
    chk("rst_in_ready", 64'(m_if.in_ready), 64'd0);
    chk("rst_out_valid", 64'(m_if.out_valid), 64'd0);
    chk("rst_out_dist", 64'(m_if.out_dist), 64'd0);
    chk("rst_done", 64'(done_m), 64'd0);
    rst = 1'b0;

    // Illegal configurations are ignored.
    do_start(16'd0, 16'd1, 5'd0);
    chk("ign_dim0", 64'(busy_m), 64'd0);
    do_start(16'd1025, 16'd1, 5'd0);
    chk("ign_dimmax", 64'(busy_m), 64'd0);
    do_start(16'd4, 16'd0, 5'd0);
    chk("ign_ns0", 64'(m_if.in_ready), 64'd0);

    // Test 1: single beat, latency check.
    dc = done_cnt;
    do_start(16'd4, 16'd1, 5'd0);
    chk("t1_busy", 64'(busy_m), 64'd1);
    send_beat(X1, Z1);
    @(negedge clk_svm);
    chk("t1_ready_drop", 64'(m_if.in_ready), 64'd0);
    repeat (3) @(negedge clk_svm);
    chk("t1_lat_early", 64'(m_if.out_valid), 64'd0);
    @(negedge clk_svm);
    chk("t1_lat_on", 64'(m_if.out_valid), 64'd1);
    get_result("t1", 64'd1634, 0, 16'd0, 1'b1);
    chk("t1_done_cnt", 64'(done_cnt - dc), 64'd1);

    // Test 2: two beats with a stall, garbage in masked lanes.
    do_start(16'd6, 16'd1, 5'd0);
    send_beat({16'd40, 16'd30, 16'd20, 16'd10}, {16'd37, 16'd33, 16'd17, 16'd13});
    repeat (3) @(negedge clk_svm);
    send_beat({16'hFFFF, 16'hFFFF, 16'd5, 16'd100}, {16'd0, 16'd0, 16'd8, 16'd103});
    get_result("t2", 64'd54, 0, 16'd0, 1'b1);

    // Test 3: three samples, back-pressure on sample 1, busy start ignored.
    dc = done_cnt;
    do_start(16'd4, 16'd3, 5'd0);
    do_start(16'd8, 16'd1, 5'd0);
    chk("t3_busy", 64'(busy_m), 64'd1);
    send_beat(X1, Z1);
    get_result("t3s0", 64'd1634, 0, 16'd0, 1'b0);
    send_beat({16'd4, 16'd3, 16'd2, 16'd1}, 64'd0);
    while (!m_if.out_valid) @(negedge clk_svm);
    held = m_if.out_dist;
    repeat (10) @(negedge clk_svm);
    chk("t3_hold_dist", 64'(m_if.out_dist), 64'(held));
    chk("t3_hold_valid", 64'(m_if.out_valid), 64'd1);
    chk("t3_hold_ready", 64'(m_if.in_ready), 64'd0);
    get_result("t3s1", 64'd30, 0, 16'd1, 1'b0);
    send_beat({16'd0, 16'd0, 16'd0, 16'd100}, {16'd0, 16'd0, 16'd100, 16'd0});
    get_result("t3s2", 64'd20000, 0, 16'd2, 1'b1);
    repeat (2) @(negedge clk_svm);
    chk("t3_done_cnt", 64'(done_cnt - dc), 64'd1);

    // Test 4: saturation in both widths, and 2^16 with masked garbage lanes.
    do_start(16'd4, 16'd1, 5'd0);
    send_beat({4{16'hFFFF}}, 64'd0);
    get_result("t4", 64'h3_FFF8_0004, 0, 16'd0, 1'b1);
    do_start(16'd1, 16'd1, 5'd0);
    send_beat({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd256}, 64'd0);
    get_result("t4b", 64'd65536, 0, 16'd0, 1'b1);

    // Test 5: gamma shift (817 when enabled, 1634 otherwise).
    do_start(16'd4, 16'd1, 5'd1);
    send_beat(X1, Z1);
    get_result("t5", 64'd1634, 1, 16'd0, 1'b1);

    // Test 6: reset mid-run, then a clean run.
    dc = done_cnt;
    do_start(16'd8, 16'd2, 5'd0);
    send_beat(X1, Z1);
    send_beat(X1, Z1);
    get_result("t6s0", 64'd3268, 0, 16'd0, 1'b0);
    send_beat(X1, Z1);
    @(negedge clk_svm);
    rst = 1'b1;
    @(negedge clk_svm);
    chk("t6_busy", 64'(busy_m), 64'd0);
    chk("t6_in_ready", 64'(m_if.in_ready), 64'd0);
    chk("t6_out_idx", 64'(m_if.out_idx), 64'd0);
    chk("t6_sat_busy", 64'(busy_s), 64'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk_svm);
    chk("t6_no_done", 64'(done_cnt - dc), 64'd0);
    chk("t6_out_valid", 64'(m_if.out_valid), 64'd0);
    do_start(16'd4, 16'd1, 5'd0);
    send_beat(X1, Z1);
    get_result("t6_fresh", 64'd1634, 0, 16'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
